// File: rtl/hot_mig_issuer.sv
// Query initiator for the hot-page tracker: issues periodic or software-requested
// queries, captures the top-K snapshot and streams qualifying page addresses out.
module hot_mig_issuer #(
    parameter int unsigned ADDR_SIZE   = 28,
    parameter int unsigned CNT_SIZE    = 13,
    parameter int unsigned CMD_WIDTH   = 4,
    parameter int unsigned TOP_K       = 5,
    parameter int unsigned PERIOD_BITS = 20,
    parameter logic [CMD_WIDTH-1:0] QUERY_CMD = CMD_WIDTH'(4'h1),
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   auto_en,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic                   sw_req,
    input  logic [CNT_SIZE-1:0]    cnt_threshold,
    output logic                   query_en,
    output logic [CMD_WIDTH-1:0]   query_cmd,
    input  logic                   query_ready,
    input  logic                   mig_en,
    input  logic [ADDR_SIZE-1:0]   top_1_addr,
    input  logic [ADDR_SIZE-1:0]   top_2_addr,
    input  logic [ADDR_SIZE-1:0]   top_3_addr,
    input  logic [ADDR_SIZE-1:0]   top_4_addr,
    input  logic [ADDR_SIZE-1:0]   top_5_addr,
    input  logic [CNT_SIZE-1:0]    top_1_cnt,
    input  logic [CNT_SIZE-1:0]    top_2_cnt,
    input  logic [CNT_SIZE-1:0]    top_3_cnt,
    input  logic [CNT_SIZE-1:0]    top_4_cnt,
    input  logic [CNT_SIZE-1:0]    top_5_cnt,
    input  logic [2:0]             num_mig,
    output logic                   mig_addr_en,
    output logic [ADDR_SIZE-1:0]   mig_addr,
    input  logic                   mig_addr_ready,
    output logic                   busy,
    output logic                   timeout_flag,
    output logic [15:0]            issued_cnt,
    output logic [15:0]            drop_cnt
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT) + 1;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUERY = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                 r_state;
    logic [PERIOD_BITS-1:0] r_timer;
    logic [WAIT_W-1:0]      r_wait;
    logic                   r_pending;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_n;
    logic [CNT_SIZE-1:0]    r_thr;
    logic [ADDR_SIZE-1:0]   r_addr [TOP_K];
    logic [CNT_SIZE-1:0]    r_cnt  [TOP_K];

    logic [ADDR_SIZE-1:0]   w_addr [TOP_K];
    logic [CNT_SIZE-1:0]    w_cnt  [TOP_K];
    logic [IDX_W-1:0]       w_num_sat;
    logic                   w_auto_hit;
    logic                   w_trigger;
    logic [IDX_W-1:0]       w_next_idx;
    logic                   w_last;
    logic                   w_next_ok;
    logic                   w_first_ok;
    logic                   w_advance;

    assign w_addr[0] = top_1_addr;
    assign w_addr[1] = top_2_addr;
    assign w_addr[2] = top_3_addr;
    assign w_addr[3] = top_4_addr;
    assign w_addr[4] = top_5_addr;
    assign w_cnt[0]  = top_1_cnt;
    assign w_cnt[1]  = top_2_cnt;
    assign w_cnt[2]  = top_3_cnt;
    assign w_cnt[3]  = top_4_cnt;
    assign w_cnt[4]  = top_5_cnt;

    // Tracker may report more than five entries; only five slots exist.
    assign w_num_sat  = (num_mig > IDX_W'(TOP_K)) ? IDX_W'(TOP_K) : num_mig;
    assign w_auto_hit = auto_en && (period != '0) &&
                        (r_timer == PERIOD_BITS'(period - PERIOD_BITS'(1)));
    assign w_trigger  = sw_req || r_pending || w_auto_hit;

    assign w_next_idx = r_idx + IDX_W'(1);
    assign w_last     = (w_next_idx == r_n);
    assign w_next_ok  = (r_cnt[w_next_idx] >= r_thr);
    assign w_first_ok = (w_cnt[0] >= cnt_threshold);
    // A presented entry waits for ready; a below-threshold entry is skipped in one cycle.
    assign w_advance  = mig_addr_en ? mig_addr_ready : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_wait       <= '0;
            r_pending    <= 1'b0;
            r_idx        <= '0;
            r_n          <= '0;
            r_thr        <= '0;
            for (int i = 0; i < TOP_K; i++) begin
                r_addr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            query_en     <= 1'b0;
            query_cmd    <= '0;
            mig_addr_en  <= 1'b0;
            mig_addr     <= '0;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
            issued_cnt   <= '0;
            drop_cnt     <= '0;
        end else begin
            // Requests arriving while busy coalesce into a single deferred query.
            if ((r_state != S_IDLE) && sw_req) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_timer <= r_timer + PERIOD_BITS'(1);
                    if (w_trigger) begin
                        r_state   <= S_QUERY;
                        r_pending <= 1'b0;
                        query_en  <= 1'b1;
                        query_cmd <= QUERY_CMD;
                        busy      <= 1'b1;
                    end
                end

                S_QUERY: begin
                    if (query_ready) begin
                        r_state   <= S_WAIT;
                        r_wait    <= '0;
                        query_en  <= 1'b0;
                        query_cmd <= '0;
                    end
                end

                S_WAIT: begin
                    if (mig_en) begin
                        for (int i = 0; i < TOP_K; i++) begin
                            r_addr[i] <= w_addr[i];
                            r_cnt[i]  <= w_cnt[i];
                        end
                        r_n   <= w_num_sat;
                        r_thr <= cnt_threshold;
                        r_idx <= '0;
                        if (w_num_sat == '0) begin
                            r_state <= S_IDLE;
                            r_timer <= '0;
                            busy    <= 1'b0;
                        end else begin
                            r_state     <= S_DRAIN;
                            mig_addr_en <= w_first_ok;
                            mig_addr    <= w_first_ok ? w_addr[0] : '0;
                        end
                    end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                        r_state      <= S_IDLE;
                        r_timer      <= '0;
                        busy         <= 1'b0;
                        timeout_flag <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end

                S_DRAIN: begin
                    if (w_advance) begin
                        if (mig_addr_en) begin
                            if (issued_cnt != {STAT_W{1'b1}}) begin
                                issued_cnt <= issued_cnt + STAT_W'(1);
                            end
                        end else if (drop_cnt != {STAT_W{1'b1}}) begin
                            drop_cnt <= drop_cnt + STAT_W'(1);
                        end
                        r_idx <= w_next_idx;
                        if (w_last) begin
                            r_state     <= S_IDLE;
                            r_timer     <= '0;
                            busy        <= 1'b0;
                            mig_addr_en <= 1'b0;
                            mig_addr    <= '0;
                        end else begin
                            mig_addr_en <= w_next_ok;
                            mig_addr    <= w_next_ok ? r_addr[w_next_idx] : '0;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hot_mig_issuer.sv
// Directed bench for hot_mig_issuer: expected migration addresses are queued by the
// stimulus and checked by an independent monitor at each stream handshake.
module tb_hot_mig_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        auto_en;
    logic [19:0] period;
    logic        sw_req;
    logic [12:0] cnt_threshold;
    logic        query_en;
    logic [3:0]  query_cmd;
    logic        query_ready;
    logic        mig_en;
    logic [27:0] top_1_addr, top_2_addr, top_3_addr, top_4_addr, top_5_addr;
    logic [12:0] top_1_cnt, top_2_cnt, top_3_cnt, top_4_cnt, top_5_cnt;
    logic [2:0]  num_mig;
    logic        mig_addr_en;
    logic [27:0] mig_addr;
    logic        mig_addr_ready;
    logic        busy;
    logic        timeout_flag;
    logic [15:0] issued_cnt;
    logic [15:0] drop_cnt;

    int          nchecks = 0;
    int          nerrors = 0;
    int          q_seen  = 0;
    logic [27:0] exp_q[$];
    logic        held;
    logic [27:0] held_addr;

    hot_mig_issuer dut (
        .clk(clk), .rst(rst), .auto_en(auto_en), .period(period), .sw_req(sw_req),
        .cnt_threshold(cnt_threshold), .query_en(query_en), .query_cmd(query_cmd),
        .query_ready(query_ready), .mig_en(mig_en),
        .top_1_addr(top_1_addr), .top_2_addr(top_2_addr), .top_3_addr(top_3_addr),
        .top_4_addr(top_4_addr), .top_5_addr(top_5_addr),
        .top_1_cnt(top_1_cnt), .top_2_cnt(top_2_cnt), .top_3_cnt(top_3_cnt),
        .top_4_cnt(top_4_cnt), .top_5_cnt(top_5_cnt), .num_mig(num_mig),
        .mig_addr_en(mig_addr_en), .mig_addr(mig_addr), .mig_addr_ready(mig_addr_ready),
        .busy(busy), .timeout_flag(timeout_flag), .issued_cnt(issued_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stream monitor: pops the scoreboard on every handshake and checks hold under backpressure.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (query_en && query_ready) q_seen++;
            if (held) begin
                nchecks++;
                if (!mig_addr_en || mig_addr !== held_addr) begin
                    nerrors++;
                    $display("FAIL hold: en=%0b addr=0x%0h expected en=1 addr=0x%0h",
                             mig_addr_en, mig_addr, held_addr);
                end
            end
            if (mig_addr_en && mig_addr_ready) begin
                nchecks++;
                if (exp_q.size() == 0) begin
                    nerrors++;
                    $display("FAIL stream: unexpected addr 0x%0h expected none", mig_addr);
                end else begin
                    logic [27:0] e;
                    e = exp_q.pop_front();
                    if (mig_addr !== e) begin
                        nerrors++;
                        $display("FAIL stream: addr 0x%0h expected 0x%0h", mig_addr, e);
                    end
                end
            end
            held      = mig_addr_en && !mig_addr_ready;
            held_addr = mig_addr;
        end
    end

    task automatic query();
        sw_req = 1'b1;
        cyc(1);
        sw_req = 1'b0;
        cyc(1);
    endtask

    // Present a snapshot for one cycle, then scramble every snapshot input.
    task automatic snap(input logic [27:0] base, input logic [27:0] step,
                        input logic [12:0] c1, input logic [12:0] c2, input logic [12:0] c3,
                        input logic [12:0] c4, input logic [12:0] c5,
                        input logic [2:0] n, input logic [12:0] thr);
        top_1_addr = base;
        top_2_addr = base + step;
        top_3_addr = base + 28'(2) * step;
        top_4_addr = base + 28'(3) * step;
        top_5_addr = base + 28'(4) * step;
        top_1_cnt = c1; top_2_cnt = c2; top_3_cnt = c3; top_4_cnt = c4; top_5_cnt = c5;
        num_mig = n;
        cnt_threshold = thr;
        mig_en = 1'b1;
        cyc(1);
        mig_en = 1'b0;
        top_1_addr = 28'hFFF_FFFF; top_2_addr = 28'hFFF_FFFE; top_3_addr = 28'hFFF_FFFD;
        top_4_addr = 28'hFFF_FFFC; top_5_addr = 28'hFFF_FFFB;
        top_1_cnt = 13'd8000; top_2_cnt = 13'd8000; top_3_cnt = 13'd8000;
        top_4_cnt = 13'd8000; top_5_cnt = 13'd8000;
        num_mig = 3'd7;
        cnt_threshold = 13'd0;
    endtask

    initial begin
        int q_before;
        rst = 1'b1; auto_en = 1'b0; period = 20'd0; sw_req = 1'b0;
        cnt_threshold = 13'd0; query_ready = 1'b1; mig_en = 1'b0; num_mig = 3'd0;
        top_1_addr = '0; top_2_addr = '0; top_3_addr = '0; top_4_addr = '0; top_5_addr = '0;
        top_1_cnt = '0; top_2_cnt = '0; top_3_cnt = '0; top_4_cnt = '0; top_5_cnt = '0;
        mig_addr_ready = 1'b1;
        cyc(3);
        check("reset_query_en", 32'(query_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_issued", 32'(issued_cnt), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Software query: one-cycle query_en with the query command.
        sw_req = 1'b1;
        cyc(1);
        sw_req = 1'b0;
        check("query_en_high", 32'(query_en), 32'd1);
        check("query_cmd", 32'(query_cmd), 32'h1);
        check("busy_in_query", 32'(busy), 32'd1);
        cyc(1);
        check("query_en_low", 32'(query_en), 32'd0);
        check("busy_waiting", 32'(busy), 32'd1);
        cyc(3);

        // Threshold filter: 0x100, 0x200 issued; 0x300 dropped.
        exp_q.push_back(28'h100);
        exp_q.push_back(28'h200);
        snap(28'h100, 28'h100, 13'd50, 13'd40, 13'd30, 13'd0, 13'd0, 3'd3, 13'd35);
        check("first_addr_latency", 32'(mig_addr_en), 32'd1);
        cyc(3);
        check("filter_issued", 32'(issued_cnt), 32'd2);
        check("filter_drop", 32'(drop_cnt), 32'd1);
        check("filter_idle", 32'(busy), 32'd0);

        // mig_en in IDLE is ignored.
        mig_en = 1'b1; num_mig = 3'd3; top_1_cnt = 13'd100; cnt_threshold = 13'd1;
        cyc(1);
        mig_en = 1'b0;
        cyc(1);
        check("idle_mig_en_busy", 32'(busy), 32'd0);
        check("idle_mig_en_addr_en", 32'(mig_addr_en), 32'd0);

        // Backpressure: address held for ten cycles, one handshake.
        mig_addr_ready = 1'b0;
        query();
        exp_q.push_back(28'h100);
        snap(28'h100, 28'h100, 13'd50, 13'd0, 13'd0, 13'd0, 13'd0, 3'd1, 13'd35);
        for (int i = 0; i < 10; i++) begin
            check("bp_en", 32'(mig_addr_en), 32'd1);
            check("bp_addr", 32'(mig_addr), 32'h100);
            cyc(1);
        end
        mig_addr_ready = 1'b1;
        cyc(1);
        check("bp_issued", 32'(issued_cnt), 32'd3);
        check("bp_idle", 32'(busy), 32'd0);

        // num_mig=7 clamps to five entries.
        query();
        for (int i = 1; i <= 5; i++) exp_q.push_back(28'(i * 'h11));
        snap(28'h11, 28'h11, 13'd100, 13'd100, 13'd100, 13'd100, 13'd100, 3'd7, 13'd35);
        cyc(5);
        check("clamp_issued", 32'(issued_cnt), 32'd8);
        check("clamp_drop", 32'(drop_cnt), 32'd1);
        check("clamp_idle", 32'(busy), 32'd0);

        // Empty snapshot returns to IDLE at once.
        query();
        snap(28'h500, 28'h1, 13'd100, 13'd100, 13'd100, 13'd100, 13'd100, 3'd0, 13'd35);
        check("empty_idle", 32'(busy), 32'd0);
        check("empty_addr_en", 32'(mig_addr_en), 32'd0);

        // Three software requests during DRAIN collapse into one query.
        mig_addr_ready = 1'b0;
        query();
        exp_q.push_back(28'hABC);
        snap(28'hABC, 28'h1, 13'd100, 13'd0, 13'd0, 13'd0, 13'd0, 3'd1, 13'd35);
        q_before = q_seen;
        for (int i = 0; i < 3; i++) begin
            sw_req = 1'b1;
            cyc(1);
            sw_req = 1'b0;
            cyc(1);
        end
        mig_addr_ready = 1'b1;
        cyc(1);
        cyc(1);
        check("pending_query_en", 32'(query_en), 32'd1);
        cyc(1);
        snap(28'h0, 28'h0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 3'd0, 13'd0);
        cyc(10);
        check("pending_one_query", 32'(q_seen), 32'(q_before + 1));
        check("pending_idle", 32'(busy), 32'd0);

        // Auto query with no response: timeout, then next query 100 cycles into IDLE.
        auto_en = 1'b1; period = 20'd100;
        for (int i = 0; i < 200 && !query_en; i++) cyc(1);
        check("auto_query_seen", 32'(query_en), 32'd1);
        cyc(1024);
        check("timeout_not_yet", 32'(timeout_flag), 32'd0);
        check("timeout_still_busy", 32'(busy), 32'd1);
        cyc(1);
        check("timeout_flag", 32'(timeout_flag), 32'd1);
        check("timeout_idle", 32'(busy), 32'd0);
        cyc(99);
        check("auto_not_early", 32'(query_en), 32'd0);
        cyc(1);
        check("auto_requery", 32'(query_en), 32'd1);
        auto_en = 1'b0;
        cyc(1);
        snap(28'h0, 28'h0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 3'd0, 13'd0);
        cyc(2);

        // Asynchronous reset mid-DRAIN.
        mig_addr_ready = 1'b0;
        query();
        snap(28'h700, 28'h100, 13'd100, 13'd100, 13'd0, 13'd0, 13'd0, 3'd2, 13'd35);
        cyc(2);
        #2 rst = 1'b1;
        #1;
        check("rst_addr_en", 32'(mig_addr_en), 32'd0);
        check("rst_addr", 32'(mig_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_issued", 32'(issued_cnt), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_timeout", 32'(timeout_flag), 32'd0);
        mig_addr_ready = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(10);
        check("post_rst_addr_en", 32'(mig_addr_en), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
        $finish;
    end

endmodule
